// File: rtl/fir_ctrl.sv
// fir_ctrl: control FSM for a chained-MAC FIR filter.
//   Loads N_TAPS coefficients from a cfg beat stream into the tap registers,
//   clears the chain, then streams samples into the chain. A LAT-deep token
//   shift register tracks which chain outputs belong to real samples, so
//   m_valid pulses exactly once per accepted sample. A flush drains the chain
//   with LAT zero samples and pulses done afterwards.
// Ports:
//   clk, rst                          clock, async active-high reset
//   cfg_start, cfg_valid/ready, data  coefficient load control and beats
//   coeff_we/addr/wdata               tap coefficient write port
//   s_valid/ready, s_data             sample input stream
//   flush                             drain request (honoured in RUN only)
//   chain_clr/en/data, chain_result   tap chain control and last-tap output
//   m_valid, m_data                   filtered result (no backpressure)
//   busy, done                        status: not IDLE/RUN; end-of-flush pulse
module fir_ctrl #(
  parameter int unsigned N_TAPS    = 8,
  parameter int unsigned DIM_DATA  = 16,
  parameter int unsigned DIM_COEFF = 16,
  parameter int unsigned DIM_ACC   = 32,
  parameter int unsigned LAT       = N_TAPS + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_start,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [DIM_COEFF-1:0]       cfg_data,
  output logic                       coeff_we,
  output logic [$clog2(N_TAPS)-1:0]  coeff_addr,
  output logic [DIM_COEFF-1:0]       coeff_wdata,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DIM_DATA-1:0]        s_data,
  input  logic                       flush,
  output logic                       chain_clr,
  output logic                       chain_en,
  output logic [DIM_DATA-1:0]        chain_data,
  input  logic [DIM_ACC-1:0]         chain_result,
  output logic                       m_valid,
  output logic [DIM_ACC-1:0]         m_data,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned AW = $clog2(N_TAPS);
  localparam int unsigned CW = $clog2(LAT + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StClear, StRun, StFlush} state_e;

  state_e         r_state, w_state_d;
  logic [AW-1:0]  r_idx, w_idx_d, w_load_idx;
  logic [CW-1:0]  r_flush_cnt, w_flush_cnt_d;
  logic [LAT-1:0] r_vsr, w_vsr_d;
  logic           r_m_valid, w_m_valid_d;
  logic [DIM_ACC-1:0] r_m_data;
  logic           r_done, w_done_d;

  logic           w_tok_in, w_clr_tok, w_chain_en, w_clr_state;
  logic           w_cfg_ready, w_coeff_we, w_s_ready;

  always_comb begin
    w_state_d     = r_state;
    w_idx_d       = r_idx;
    w_flush_cnt_d = r_flush_cnt;
    w_load_idx    = r_idx;
    w_tok_in      = 1'b0;
    w_clr_tok     = 1'b0;
    w_chain_en    = 1'b0;
    w_clr_state   = 1'b0;
    w_cfg_ready   = 1'b0;
    w_coeff_we    = 1'b0;
    w_s_ready     = 1'b0;
    w_done_d      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (cfg_start) begin
          w_state_d = StLoad;
          w_idx_d   = '0;
        end
      end
      StLoad: begin
        w_cfg_ready = 1'b1;
        // A restart pulse lands any same-cycle beat at index 0.
        w_load_idx  = cfg_start ? '0 : r_idx;
        w_idx_d     = w_load_idx;
        if (cfg_valid) begin
          w_coeff_we = 1'b1;
          if (w_load_idx == AW'(N_TAPS - 1)) begin
            w_state_d = StClear;
          end else begin
            w_idx_d = w_load_idx + AW'(1);
          end
        end
      end
      StClear: begin
        w_clr_state = 1'b1;
        w_clr_tok   = 1'b1;
        w_state_d   = StRun;
      end
      StRun: begin
        if (cfg_start) begin
          w_state_d     = StLoad;
          w_idx_d       = '0;
          w_flush_cnt_d = '0;
          w_clr_tok     = 1'b1;
        end else begin
          w_s_ready  = 1'b1;
          w_chain_en = s_valid;
          w_tok_in   = s_valid;
          if (flush) begin
            w_state_d     = StFlush;
            w_flush_cnt_d = CW'(LAT);
          end
        end
      end
      StFlush: begin
        if (cfg_start) begin
          w_state_d     = StLoad;
          w_idx_d       = '0;
          w_flush_cnt_d = '0;
          w_clr_tok     = 1'b1;
        end else begin
          w_chain_en = 1'b1;
          if (r_flush_cnt <= CW'(1)) begin
            w_state_d     = StRun;
            w_flush_cnt_d = '0;
            w_done_d      = 1'b1;
          end else begin
            w_flush_cnt_d = r_flush_cnt - CW'(1);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Tokens move only with the chain; a token leaving the last stage means the
  // chain output in this cycle is the result for a real sample.
  always_comb begin
    w_vsr_d     = r_vsr;
    w_m_valid_d = 1'b0;
    if (w_clr_tok) begin
      w_vsr_d = '0;
    end else if (w_chain_en) begin
      w_vsr_d     = (r_vsr << 1) | LAT'(w_tok_in);
      w_m_valid_d = r_vsr[LAT-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_flush_cnt <= '0;
      r_vsr       <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_idx       <= w_idx_d;
      r_flush_cnt <= w_flush_cnt_d;
      r_vsr       <= w_vsr_d;
      r_m_valid   <= w_m_valid_d;
      r_done      <= w_done_d;
      if (w_m_valid_d) begin
        r_m_data <= chain_result;
      end
    end
  end

  assign cfg_ready   = w_cfg_ready;
  assign coeff_we    = w_coeff_we;
  assign coeff_addr  = w_coeff_we ? w_load_idx : '0;
  assign coeff_wdata = w_coeff_we ? cfg_data : '0;
  assign s_ready     = w_s_ready;
  assign chain_en    = w_chain_en;
  assign chain_data  = w_tok_in ? s_data : '0;
  // Reset holds the chain cleared without waiting for a clock.
  assign chain_clr   = w_clr_state | rst;
  assign m_valid     = r_m_valid;
  assign m_data      = r_m_data;
  assign busy        = (r_state == StLoad) || (r_state == StClear) || (r_state == StFlush);
  assign done        = r_done;

endmodule

// File: tb/tb_fir_ctrl.sv
`timescale 1ns/1ps
module tb_fir_ctrl;
  localparam int N_TAPS    = 8;
  localparam int DIM_DATA  = 16;
  localparam int DIM_COEFF = 16;
  localparam int DIM_ACC   = 32;
  localparam int LAT       = N_TAPS + 1;
  localparam int AW        = $clog2(N_TAPS);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_start, cfg_valid, cfg_ready;
  logic [DIM_COEFF-1:0] cfg_data;
  logic                 coeff_we;
  logic [AW-1:0]        coeff_addr;
  logic [DIM_COEFF-1:0] coeff_wdata;
  logic                 s_valid, s_ready;
  logic [DIM_DATA-1:0]  s_data;
  logic                 flush;
  logic                 chain_clr, chain_en;
  logic [DIM_DATA-1:0]  chain_data;
  logic [DIM_ACC-1:0]   chain_result;
  logic                 m_valid;
  logic [DIM_ACC-1:0]   m_data;
  logic                 busy, done;

  always #5 clk = ~clk;

  fir_ctrl #(
    .N_TAPS(N_TAPS), .DIM_DATA(DIM_DATA), .DIM_COEFF(DIM_COEFF), .DIM_ACC(DIM_ACC), .LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_wdata(coeff_wdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .flush(flush),
    .chain_clr(chain_clr), .chain_en(chain_en), .chain_data(chain_data),
    .chain_result(chain_result), .m_valid(m_valid), .m_data(m_data), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Stand-in tap chain: a LAT-stage delay line on chain_en, result = 3*x+256.
  function automatic logic [DIM_ACC-1:0] res_of(input logic [DIM_DATA-1:0] d);
    return DIM_ACC'(d) * DIM_ACC'(3) + DIM_ACC'(256);
  endfunction

  logic [DIM_DATA-1:0] dl [LAT];
  always @(posedge clk) begin
    if (chain_clr) begin
      for (int i = 0; i < LAT; i++) dl[i] <= '0;
    end else if (chain_en) begin
      dl[0] <= chain_data;
      for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end
  end
  assign chain_result = res_of(dl[LAT-1]);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: spec-level mode plus a queue of in-flight samples, each
  // with the number of further chain enables it still needs.
  typedef enum int {MIdle, MLoad, MClear, MRun, MFlush} mode_t;
  typedef struct {
    logic [DIM_DATA-1:0] data;
    int                  left;
  } tok_t;

  tok_t  tq[$];
  tok_t  tnew;
  mode_t md_mode, n_mode;
  int    md_beat, n_beat, md_fl, n_fl, e_eff;
  logic  exp_mv, exp_done, n_mv, n_done;
  logic [DIM_ACC-1:0] exp_md, n_md;
  logic  e_sready, e_en, e_xfer, e_we, e_clr, e_busy, e_cfgr, e_kill;

  always @(negedge clk) begin
    if (rst) begin
      md_mode = MIdle; md_beat = 0; md_fl = 0; tq.delete();
      exp_mv = 1'b0; exp_md = '0; exp_done = 1'b0;
      check("rst_chain_clr", 64'(chain_clr), 64'(1));
      check("rst_s_ready",   64'(s_ready),   64'(0));
      check("rst_chain_en",  64'(chain_en),  64'(0));
      check("rst_m_valid",   64'(m_valid),   64'(0));
      check("rst_busy",      64'(busy),      64'(0));
      check("rst_done",      64'(done),      64'(0));
    end else begin
      e_sready = 0; e_en = 0; e_xfer = 0; e_we = 0; e_clr = 0; e_busy = 0; e_cfgr = 0;
      e_kill = 0; e_eff = 0;
      n_mode = md_mode; n_beat = md_beat; n_fl = md_fl; n_mv = 0; n_md = '0; n_done = 0;
      case (md_mode)
        MIdle: if (cfg_start) begin n_mode = MLoad; n_beat = 0; end
        MLoad: begin
          e_busy = 1; e_cfgr = 1;
          e_eff  = cfg_start ? 0 : md_beat;
          n_beat = e_eff;
          if (cfg_valid) begin
            e_we = 1;
            if (e_eff == N_TAPS - 1) n_mode = MClear;
            else n_beat = e_eff + 1;
          end
        end
        MClear: begin e_busy = 1; e_clr = 1; e_kill = 1; n_mode = MRun; end
        MRun: begin
          if (cfg_start) begin
            n_mode = MLoad; n_beat = 0; n_fl = 0; e_kill = 1;
          end else begin
            e_sready = 1; e_en = s_valid; e_xfer = s_valid;
            if (flush) begin n_mode = MFlush; n_fl = LAT; end
          end
        end
        MFlush: begin
          e_busy = 1;
          if (cfg_start) begin
            n_mode = MLoad; n_beat = 0; n_fl = 0; e_kill = 1;
          end else begin
            e_en = 1; n_fl = md_fl - 1;
            if (n_fl == 0) begin n_mode = MRun; n_done = 1; end
          end
        end
        default: n_mode = MIdle;
      endcase
      // The cycle that abandons RUN/FLUSH for a reload has no defined stream behaviour.
      if (!(cfg_start && (md_mode == MRun || md_mode == MFlush))) begin
        check("s_ready",    64'(s_ready),    64'(e_sready));
        check("chain_en",   64'(chain_en),   64'(e_en));
        check("chain_data", 64'(chain_data), e_xfer ? 64'(s_data) : 64'(0));
      end
      check("chain_clr", 64'(chain_clr), 64'(e_clr));
      check("busy",      64'(busy),      64'(e_busy));
      check("cfg_ready", 64'(cfg_ready), 64'(e_cfgr));
      check("coeff_we",  64'(coeff_we),  64'(e_we));
      if (e_we) begin
        check("coeff_addr",  64'(coeff_addr),  64'(e_eff));
        check("coeff_wdata", 64'(coeff_wdata), 64'(cfg_data));
      end
      check("m_valid", 64'(m_valid), 64'(exp_mv));
      if (exp_mv) check("m_data", 64'(m_data), 64'(exp_md));
      check("done", 64'(done), 64'(exp_done));
      if (e_en) begin
        if (tq.size() > 0 && tq[0].left == 0) begin
          n_mv = 1; n_md = res_of(tq[0].data);
          void'(tq.pop_front());
        end
        for (int i = 0; i < tq.size(); i++) tq[i].left = tq[i].left - 1;
        if (e_xfer) begin
          tnew.data = s_data; tnew.left = LAT - 1;
          tq.push_back(tnew);
        end
      end
      if (e_kill) tq.delete();
      md_mode = n_mode; md_beat = n_beat; md_fl = n_fl;
      exp_mv = n_mv; exp_md = n_md; exp_done = n_done;
    end
  end

  // Event monitor feeding the hand-computed directed expectations.
  logic [AW-1:0]        we_addr[$];
  logic [DIM_COEFF-1:0] we_data[$];
  int clr_cnt, en_cnt, mv_cnt, done_cnt, sready_lo, flush_nz, mv_after_idle;
  int first_en, first_mv, done_cyc;
  logic [DIM_ACC-1:0] first_md;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_en = 1'b0;
    end else begin
      if (coeff_we) begin we_addr.push_back(coeff_addr); we_data.push_back(coeff_wdata); end
      if (chain_clr) clr_cnt++;
      if (chain_en) begin en_cnt++; if (first_en < 0) first_en = cyc; end
      if (m_valid) begin
        mv_cnt++;
        if (first_mv < 0) begin first_mv = cyc; first_md = m_data; end
        if (!prev_en) mv_after_idle++;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (!s_ready) sready_lo++;
      if (chain_en && !s_ready && chain_data != '0) flush_nz++;
      prev_en = chain_en;
    end
  end

  task automatic clr_counters();
    we_addr.delete(); we_data.delete();
    clr_cnt = 0; en_cnt = 0; mv_cnt = 0; done_cnt = 0; sready_lo = 0; flush_nz = 0;
    mv_after_idle = 0; first_en = -1; first_mv = -1; done_cyc = -1; first_md = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int flush_cyc;

  initial begin
    rst = 1'b1; cfg_start = 0; cfg_valid = 0; cfg_data = '0;
    s_valid = 0; s_data = '0; flush = 0;
    clr_counters();
    repeat (3) tick();
    check("reset_chain_clr", 64'(chain_clr), 64'(1));
    check("reset_s_ready",   64'(s_ready),   64'(0));
    rst = 1'b0;
    tick();

    // Load 1..8 with a gap after every beat.
    clr_counters();
    cfg_start = 1; tick(); cfg_start = 0;
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1; cfg_data = DIM_COEFF'(i + 1); tick();
      cfg_valid = 0; tick();
    end
    check("load_beats", 64'(we_addr.size()), 64'(8));
    for (int i = 0; i < 8; i++) begin
      if (i < we_addr.size()) begin
        check("load_addr",  64'(we_addr[i]), 64'(i));
        check("load_wdata", 64'(we_data[i]), 64'(i + 1));
      end
    end
    check("load_clr_cycles", 64'(clr_cnt), 64'(1));
    check("run_s_ready",     64'(s_ready), 64'(1));
    check("run_busy",        64'(busy),    64'(0));

    // 20 back-to-back samples, then drain.
    clr_counters();
    for (int i = 0; i < 20; i++) begin
      s_valid = 1; s_data = DIM_DATA'(i * 7 + 5); tick();
    end
    s_valid = 0; tick();
    check("stream_en_cycles", 64'(en_cnt), 64'(20));
    flush = 1; tick(); flush = 0;
    repeat (14) tick();
    check("stream_results",  64'(mv_cnt), 64'(20));
    check("stream_latency",  64'(first_mv - first_en), 64'(10));
    check("stream_first_md", 64'(first_md), 64'(271));
    check("stream_done",     64'(done_cnt), 64'(1));

    // One sample every third cycle, then drain.
    clr_counters();
    for (int i = 0; i < 45; i++) begin
      s_valid = (i % 3 == 0); s_data = DIM_DATA'(i + 100); tick();
    end
    s_valid = 0; flush = 1; tick(); flush = 0;
    repeat (14) tick();
    check("sparse_results",  64'(mv_cnt), 64'(15));
    check("sparse_en",       64'(en_cnt), 64'(24));
    check("sparse_mv_idle",  64'(mv_after_idle), 64'(0));

    // Flush with three samples in flight.
    clr_counters();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1; s_data = DIM_DATA'(16'h11 * (i + 1)); tick();
    end
    s_valid = 0; flush = 1; flush_cyc = cyc; tick(); flush = 0;
    repeat (15) tick();
    check("flush_sready_low", 64'(sready_lo), 64'(9));
    check("flush_zero_data",  64'(flush_nz),  64'(0));
    check("flush_results",    64'(mv_cnt),    64'(3));
    check("flush_done_count", 64'(done_cnt),  64'(1));
    check("flush_done_cycle", 64'(done_cyc - flush_cyc), 64'(10));
    check("flush_back_run",   64'(s_ready),   64'(1));

    // cfg_start beats flush with five tokens in flight.
    clr_counters();
    for (int i = 0; i < 5; i++) begin
      s_valid = 1; s_data = DIM_DATA'(i + 1); tick();
    end
    s_valid = 0; cfg_start = 1; flush = 1; tick(); cfg_start = 0; flush = 0;
    repeat (15) tick();
    check("abort_results",   64'(mv_cnt),    64'(0));
    check("abort_done",      64'(done_cnt),  64'(0));
    check("abort_busy",      64'(busy),      64'(1));
    check("abort_cfg_ready", 64'(cfg_ready), 64'(1));
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1; cfg_data = DIM_COEFF'(16'h10 + i); tick();
    end
    cfg_valid = 0; tick();
    check("reload_beats",   64'(we_addr.size()), 64'(8));
    check("reload_s_ready", 64'(s_ready), 64'(1));

    // Asynchronous reset in the middle of a flush.
    clr_counters();
    for (int i = 0; i < 2; i++) begin
      s_valid = 1; s_data = DIM_DATA'(i + 9); tick();
    end
    s_valid = 0; flush = 1; tick(); flush = 0;
    tick(); tick();
    check("pre_rst_busy", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_chain_clr",   64'(chain_clr),   64'(1));
    check("arst_m_valid",     64'(m_valid),     64'(0));
    check("arst_m_data",      64'(m_data),      64'(0));
    check("arst_busy",        64'(busy),        64'(0));
    check("arst_s_ready",     64'(s_ready),     64'(0));
    check("arst_chain_en",    64'(chain_en),    64'(0));
    check("arst_chain_data",  64'(chain_data),  64'(0));
    check("arst_done",        64'(done),        64'(0));
    check("arst_cfg_ready",   64'(cfg_ready),   64'(0));
    check("arst_coeff_we",    64'(coeff_we),    64'(0));
    check("arst_coeff_addr",  64'(coeff_addr),  64'(0));
    check("arst_coeff_wdata", 64'(coeff_wdata), 64'(0));
    repeat (2) tick();
    rst = 1'b0;
    clr_counters();
    s_valid = 1; s_data = 16'h5;
    repeat (6) tick();
    s_valid = 0;
    repeat (12) tick();
    check("post_rst_en",      64'(en_cnt),  64'(0));
    check("post_rst_results", 64'(mv_cnt),  64'(0));
    check("post_rst_s_ready", 64'(s_ready), 64'(0));
    check("post_rst_busy",    64'(busy),    64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_ctrl.md
FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 Parameter N_TAPS, default 8: number of chained MAC taps and coefficients per load (2..64).
REQ-002 Parameter DIM_DATA, default 16: sample width.
REQ-003 Parameter DIM_COEFF, default 16: coefficient width.
REQ-004 Parameter DIM_ACC, default 32: chain result width.
REQ-005 Parameter LAT, default N_TAPS+1: chain_en cycles from a sample's enable to its result at chain_result.
REQ-006 One clock and one reset. Reset is asynchronous and active-high. Ports are named clk and rst.
REQ-007 clk  in  1  rising-edge clock for all state.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 cfg_start  in  1  one-cycle pulse that begins a coefficient load.
REQ-010 cfg_valid  in  1  cfg_data beat valid; cfg_ready  out  1  beat accepted when cfg_valid&cfg_ready.
REQ-011 cfg_data  in  DIM_COEFF  coefficient beat, tap 0 first.
REQ-012 coeff_we  out  1; coeff_addr  out  ceil(log2(N_TAPS)); coeff_wdata  out  DIM_COEFF  write port to the tap coefficient registers.
REQ-013 s_valid  in  1; s_ready  out  1; s_data  in  DIM_DATA  sample stream; transfer on s_valid&s_ready.
REQ-014 flush  in  1  one-cycle pulse that drains the chain with zero samples.
REQ-015 chain_clr  out  1; chain_en  out  1; chain_data  out  DIM_DATA  drive the tap chain's clr, en and data_in.
REQ-016 chain_result  in  DIM_ACC  adder output of the last tap.
REQ-017 m_valid  out  1; m_data  out  DIM_ACC  filtered result; there is no backpressure.
REQ-018 busy  out  1  high in every state except IDLE and RUN; done  out  1  one-cycle pulse at the end of a flush.

Function
REQ-019 States: IDLE, LOAD, CLEAR, RUN, FLUSH. The state is registered and the next-state logic is combinational.
REQ-020 IDLE: cfg_start goes to LOAD; flush and s_valid are ignored; s_ready=0.
REQ-021 LOAD: cfg_ready=1. Each accepted beat drives coeff_we=1, coeff_addr=beat index (0..N_TAPS-1) and coeff_wdata=cfg_data combinationally in the same cycle. The beat with index N_TAPS-1 goes to CLEAR.
REQ-022 LOAD with cfg_valid=0 holds state and index with no timeout. cfg_start in LOAD restarts the index at 0.
REQ-023 CLEAR lasts exactly one cycle: chain_clr=1, chain_en=0, valid tokens cleared; next state is RUN.
REQ-024 RUN: s_ready=1 and chain_en = s_valid.
REQ-025 On each transfer, chain_data = s_data combinationally in the same cycle, and a 1 token enters the LAT-bit valid shift register.
REQ-026 When chain_en=0, chain_data=0 and the valid shift register holds.
REQ-027 The valid shift register advances only on chain_en=1.
REQ-028 m_valid is registered. It is 1 in the cycle after a chain_en cycle in which a 1 token shifts out of stage LAT-1. m_data equals chain_result in that same cycle. m_valid is exactly one pulse per accepted sample.
REQ-029 FLUSH: s_ready=0, chain_en=1, chain_data=0, 0 tokens enter, for exactly LAT cycles counted by a down-counter. The next state is RUN, and done pulses in the cycle after the last flush cycle.
REQ-030 Tokens already in flight when FLUSH is entered still produce m_valid.
REQ-031 cfg_start is also accepted in RUN and FLUSH: go to LOAD, clear all tokens and the flush counter, and suppress any pending m_valid.
REQ-032 cfg_start and flush in the same cycle: cfg_start wins. flush outside RUN is ignored.
REQ-033 Streaming at full rate gives a throughput of one sample per clk. m_valid follows with latency LAT+1 cycles from the transfer.
REQ-034 The beat index and flush counter saturate at their terminal values and never wrap.

Reset
REQ-035 While rst=1, and immediately on its assertion: state=IDLE, index=0, flush counter=0, valid shift register=0.
REQ-036 While rst=1: cfg_ready, coeff_we, s_ready, chain_en, m_valid, busy and done are 0; coeff_addr, coeff_wdata, chain_data and m_data are 0.
REQ-037 While rst=1: chain_clr=1, so the chain is held cleared.
REQ-038 Reset deassertion mid-LOAD or mid-FLUSH resumes in IDLE. A new load is required before samples are accepted.

Verification
REQ-039 Load 8 beats 1..8 with cfg_valid gapped every other cycle -> coeff_we pulses at addr 0..7 with wdata 1..8, chain_clr for 1 cycle, then RUN with s_ready=1.
REQ-040 RUN, 20 consecutive samples -> chain_en high for 20 cycles, 20 m_valid pulses starting 10 cycles after the first transfer (N_TAPS=8), and m_data equals chain_result in each pulse.
REQ-041 Sparse s_valid (1 in 3) -> m_valid count equals accepted count, and no m_valid appears while chain_en is idle.
REQ-042 flush after 3 samples -> s_ready=0 for 9 cycles, chain_data=0, the 3 results still emerge, and done pulses once before RUN resumes.
REQ-043 cfg_start and flush together in RUN with 5 tokens in flight -> LOAD entered, zero m_valid pulses afterwards, and no done pulse.
REQ-044 rst asserted mid-FLUSH -> all outputs take their reset values asynchronously; after release the block is in IDLE and ignores s_valid.
